// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg -- width helpers and parameter legality checks for sync_fifo_prog.
// Revision 1.0
`default_nettype none

package sync_fifo_pkg;

   function automatic int ptr_w(input int depth);
      return $clog2(depth);
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   function automatic bit depth_ok(input int depth);
      return (depth >= 4) && ((depth & (depth - 1)) == 0);
   endfunction

   function automatic bit levels_ok(input int depth, input int af, input int ae);
      return (ae >= 1) && (ae < af) && (af <= depth - 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem -- 1W/1R storage array, synchronous write, asynchronous read, no reset.
// Revision 1.0
`default_nettype none

module sync_fifo_mem
   import sync_fifo_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [ptr_w(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]        wdata,
   input  logic [ptr_w(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]        rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog -- single-clock FIFO with count, programmable thresholds and error pulses.
// Define SYNC_FIFO_PROG_FWFT_EN for a first-word-fall-through read port. Revision 1.0
`default_nettype none

module sync_fifo_prog
   import sync_fifo_pkg::*;
#(
   parameter int DEPTH    = 16,
   parameter int WIDTH    = 8,
   parameter int AF_LEVEL = DEPTH - 4,
   parameter int AE_LEVEL = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    wr_en_i,
   input  logic [WIDTH-1:0]        wdata_i,
   input  logic                    rd_en_i,
   output logic [WIDTH-1:0]        rdata_o,
   output logic [cnt_w(DEPTH)-1:0] count_o,
   output logic                    full_o,
   output logic                    empty_o,
   output logic                    almost_full_o,
   output logic                    almost_empty_o,
   output logic                    wr_error_o,
   output logic                    rd_error_o
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
   localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

   if (!depth_ok(DEPTH)) begin : g_bad_depth
      $error("sync_fifo_prog: DEPTH must be a power of two and at least 4");
   end
   if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
      $error("sync_fifo_prog: need 1 <= AE_LEVEL < AF_LEVEL <= DEPTH-1");
   end

   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [CW-1:0]    count_nxt;
   logic [WIDTH-1:0] mem_rdata;
   logic             rd_acc;
   logic             wr_acc;

   // A read while full frees the slot the same-cycle write lands in.
   assign rd_acc = rd_en_i && !empty_o;
   assign wr_acc = wr_en_i && (!full_o || rd_en_i);

   always_comb begin
      count_nxt = count_o;
      if (wr_acc && !rd_acc)      count_nxt = count_o + CW'(1);
      else if (rd_acc && !wr_acc) count_nxt = count_o - CW'(1);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         count_o        <= '0;
         full_o         <= 1'b0;
         empty_o        <= 1'b1;
         almost_full_o  <= 1'b0;
         almost_empty_o <= 1'b1;
         wr_error_o     <= 1'b0;
         rd_error_o     <= 1'b0;
      end else begin
         if (wr_acc) wr_ptr <= wr_ptr + PW'(1);
         if (rd_acc) rd_ptr <= rd_ptr + PW'(1);
         count_o        <= count_nxt;
         full_o         <= (count_nxt == DEPTH_C);
         empty_o        <= (count_nxt == '0);
         almost_full_o  <= (count_nxt >= AF_C);
         almost_empty_o <= (count_nxt <= AE_C);
         wr_error_o     <= wr_en_i && full_o && !rd_en_i;
         rd_error_o     <= rd_en_i && empty_o;
      end
   end

   sync_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH)
   ) u_mem (
      .clk   (clk_i),
      .we    (wr_acc),
      .waddr (wr_ptr),
      .wdata (wdata_i),
      .raddr (rd_ptr),
      .rdata (mem_rdata)
   );

`ifdef SYNC_FIFO_PROG_FWFT_EN
   assign rdata_o = mem_rdata;
`else
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)       rdata_o <= '0;
      else if (rd_acc) rdata_o <= mem_rdata;
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog -- directed self-checking bench for sync_fifo_prog (default parameters).
// Revision 1.0
`default_nettype none

module tb_sync_fifo_prog;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       wr_en = 1'b0;
   logic [7:0] wdata = '0;
   logic       rd_en = 1'b0;
   logic [7:0] rdata;
   logic [4:0] count;
   logic       full, empty, afull, aempty, wr_err, rd_err;

   int checks = 0;
   int errors = 0;

   sync_fifo_prog #(
      .DEPTH    (16),
      .WIDTH    (8),
      .AF_LEVEL (12),
      .AE_LEVEL (2)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .wr_en_i        (wr_en),
      .wdata_i        (wdata),
      .rd_en_i        (rd_en),
      .rdata_o        (rdata),
      .count_o        (count),
      .full_o         (full),
      .empty_o        (empty),
      .almost_full_o  (afull),
      .almost_empty_o (aempty),
      .wr_error_o     (wr_err),
      .rd_error_o     (rd_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("rst_count", 32'(count), 0);
      check("rst_empty", 32'(empty), 1);
      check("rst_aempty", 32'(aempty), 1);
      check("rst_full", 32'(full), 0);
      check("rst_afull", 32'(afull), 0);
      check("rst_errs", {30'd0, wr_err, rd_err}, 0);
`ifndef SYNC_FIFO_PROG_FWFT_EN
      check("rst_rdata", 32'(rdata), 0);
`endif
      rst = 1'b0;

      // Fill 0x00..0x0F
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wdata = 8'(i);
         step();
         check("fill_count", 32'(count), 32'(i + 1));
         check("fill_full", 32'(full), 32'(i == 15));
         check("fill_afull", 32'(afull), 32'(i + 1 >= 12));
         check("fill_aempty", 32'(aempty), 32'(i + 1 <= 2));
         check("fill_empty", 32'(empty), 0);
      end

      // Overflow: writes at full are dropped
      for (int i = 0; i < 3; i++) begin
         wr_en = 1'b1; wdata = 8'hFF;
         step();
         check("ovf_err", 32'(wr_err), 1);
         check("ovf_count", 32'(count), 16);
      end
      wr_en = 1'b0;
      step();
      check("ovf_err_clear", 32'(wr_err), 0);

      // Drain: order 0x00..0x0F proves overflow data never landed
      for (int i = 0; i < 16; i++) begin
         rd_en = 1'b1;
`ifdef SYNC_FIFO_PROG_FWFT_EN
         check("drain_data", 32'(rdata), 32'(i));
`endif
         step();
`ifndef SYNC_FIFO_PROG_FWFT_EN
         check("drain_data", 32'(rdata), 32'(i));
`endif
         check("drain_count", 32'(count), 32'(15 - i));
         check("drain_empty", 32'(empty), 32'(i == 15));
         check("drain_rderr", 32'(rd_err), 0);
      end

      // Underflow, then empty with both enables
      rd_en = 1'b1;
      step();
      check("udf_err", 32'(rd_err), 1);
      check("udf_count", 32'(count), 0);
`ifndef SYNC_FIFO_PROG_FWFT_EN
      check("udf_rdata_hold", 32'(rdata), 32'h0F);
`endif
      wr_en = 1'b1; wdata = 8'hA5;
      step();
      check("both_empty_err", 32'(rd_err), 1);
      check("both_empty_count", 32'(count), 1);
      check("both_empty_empty", 32'(empty), 0);
      wr_en = 1'b0; rd_en = 1'b0;
      step();
      check("rderr_clear", 32'(rd_err), 0);
      rd_en = 1'b1;
`ifdef SYNC_FIFO_PROG_FWFT_EN
      check("a5_data", 32'(rdata), 32'hA5);
`endif
      step();
`ifndef SYNC_FIFO_PROG_FWFT_EN
      check("a5_data", 32'(rdata), 32'hA5);
`endif
      check("a5_count", 32'(count), 0);
      rd_en = 1'b0;

      // Fill with 0x20.. then full pass-through across pointer wrap
      for (int i = 0; i < 16; i++) begin
         wr_en = 1'b1; wdata = 8'(8'h20 + i);
         step();
      end
      check("pt_full", 32'(full), 1);
      for (int i = 0; i < 20; i++) begin
         wr_en = 1'b1; rd_en = 1'b1; wdata = 8'h5A;
`ifdef SYNC_FIFO_PROG_FWFT_EN
         check("pt_data", 32'(rdata), (i < 16) ? 32'(8'h20 + i) : 32'h5A);
`endif
         step();
`ifndef SYNC_FIFO_PROG_FWFT_EN
         check("pt_data", 32'(rdata), (i < 16) ? 32'(8'h20 + i) : 32'h5A);
`endif
         check("pt_count", 32'(count), 16);
         check("pt_errs", {30'd0, wr_err, rd_err}, 0);
      end
      wr_en = 1'b0;

      // Drain 9 to reach count 7, then async reset between edges
      for (int i = 0; i < 9; i++) begin
         rd_en = 1'b1;
         step();
      end
      rd_en = 1'b0;
      check("pre_rst_count", 32'(count), 7);
      check("pre_rst_data", 32'(rdata), 32'h5A);
      #2 rst = 1'b1;
      #1;
      check("arst_count", 32'(count), 0);
      check("arst_empty", 32'(empty), 1);
      check("arst_aempty", 32'(aempty), 1);
      check("arst_full", 32'(full), 0);
      check("arst_afull", 32'(afull), 0);
`ifndef SYNC_FIFO_PROG_FWFT_EN
      check("arst_rdata", 32'(rdata), 0);
`endif
      #10 rst = 1'b0;
      wr_en = 1'b1; wdata = 8'h11;
      step();
      wr_en = 1'b0;
      check("post_rst_count", 32'(count), 1);
      rd_en = 1'b1;
`ifdef SYNC_FIFO_PROG_FWFT_EN
      check("post_rst_data", 32'(rdata), 32'h11);
`endif
      step();
`ifndef SYNC_FIFO_PROG_FWFT_EN
      check("post_rst_data", 32'(rdata), 32'h11);
`endif
      check("post_rst_empty", 32'(empty), 1);
      rd_en = 1'b0;

`ifdef SYNC_FIFO_PROG_FWFT_EN
      wr_en = 1'b1; wdata = 8'h3C;
      step();
      wr_en = 1'b0;
      check("fwft_head", 32'(rdata), 32'h3C);
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("fwft_pop_empty", 32'(empty), 1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
